// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: IDLE -> WAIT -> RESP, big-endian byte/half/word access.
// Optional misalignment error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    input  logic [0:1]  req_size,
    input  logic        req_sign,
    output logic        stall,
    output logic        resp_valid,
    output logic [0:31] resp_rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Ports are numbered MSB-first; copying into [31:0] keeps the numeric value,
    // so bit k below is the 2^k bit and lane offset 0 is bits [31:24].
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [1:0]  size_in;
    assign addr_in  = req_addr;
    assign wdata_in = req_wdata;
    assign size_in  = req_size;

    logic unused_addr;
    assign unused_addr = ^addr_in;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          is_byte, is_half, is_word;
    logic [1:0]    off;
    logic          acc_err;
    assign idx     = addr_q[AW+1:2];
    assign is_byte = (size_q == 2'b10);
    assign is_half = (size_q == 2'b01);
    assign is_word = !is_byte && !is_half;

`ifdef DMEM_ALIGN_CHECK_EN
    assign off     = addr_q[1:0];
    assign acc_err = (is_half && off[0]) || (is_word && (off != 2'b00));
`else
    assign off     = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
    assign acc_err = 1'b0;
`endif

    logic [31:0] mem_word, st_data, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  be;
    assign mem_word = mem[idx];
    assign ld_byte  = 8'(mem_word >> {~off, 3'b000});
    assign ld_half  = off[1] ? mem_word[15:0] : mem_word[31:16];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        be      = 4'b1111;
        st_data = wdata_q;
        ld_data = mem_word;
        if (is_byte) begin
            be      = 4'b1000 >> off;
            st_data = {4{wdata_q[7:0]}};
            ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            be      = off[1] ? 4'b0011 : 4'b1100;
            st_data = {2{wdata_q[15:0]}};
            ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
        end
    end

    logic do_access, do_write;
    assign do_access = (state_q == S_WAIT) && (cnt_q == '0);
    assign do_write  = do_access && we_q && !acc_err;

    // NOTE: storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = addr_in[AW+1:0];
                    wdata_d = wdata_in;
                    size_d  = size_in;
                    sign_d  = req_sign;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    err_d   = acc_err;
                    rdata_d = (we_q || acc_err) ? 32'd0 : ld_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign err        = resp_valid & err_q;
    assign stall      = (state_q == S_WAIT) || ((state_q == S_IDLE) && req_valid);

endmodule
